// File: rtl/multiplier_s_c3x3_f1_9x9.sv
// ----------------------------------------------------------------------------
// multiplier_s_c3x3_f1_9x9
//
// Registered 9x9-bit fractured multiplier for the PIRDSP datapath.
//   * Full mode : C = A * B (18-bit), each operand signed or unsigned.
//   * Dual mode : two independent 4x4 products packed into one word,
//                 C[17:10] = A[8:5]*B[8:5], C[9:8] = 0, C[7:0] = A[3:0]*B[3:0].
//   * Idle      : HALF_1 = HALF_0 = 0 gives C = 0.
//
// The full product is built from a 3x3 grid of 3-bit digit partial products.
// Only the top digit of each operand carries sign weight, so every partial
// product is a small signed 4x4 multiply and the grid sum is exact for all
// sign combinations.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-high reset (clears C)
//   A       in   9   multiplicand
//   B       in   9   multiplier
//   A_sign  in   1   1 = A fields are two's complement
//   B_sign  in   1   1 = B fields are two's complement
//   HALF_0  in   1   select full 9x9 mode
//   HALF_1  in   1   select dual 4x4 mode (priority over HALF_0)
//   C       out  18  registered product(s)
//
// Configuration macro
//   MULT_IN_REG_EN  defined   : inputs pass through a register stage first,
//                               latency 2 cycles.
//                   undefined : product logic fed from the ports,
//                               latency 1 cycle.
// ----------------------------------------------------------------------------
module multiplier_s_c3x3_f1_9x9 (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  A,
   input  logic [8:0]  B,
   input  logic        A_sign,
   input  logic        B_sign,
   input  logic        HALF_0,
   input  logic        HALF_1,
   output logic [17:0] C
);

   localparam int A_W = 9;
   localparam int B_W = 9;
   localparam int C_W = A_W + B_W;

   // -------------------------------------------------------------------------
   // Full 9x9 product from a 3x3 grid of 3-bit digits.
   // Digits 0 and 1 are unsigned; digit 2 is extended by one bit which is the
   // sign bit when the operand is signed, giving it weight -4*64 = -256 on A[8].
   // -------------------------------------------------------------------------
   function automatic logic [C_W-1:0] grid_mult(
      input logic [A_W-1:0] a,
      input logic           a_sgn,
      input logic [B_W-1:0] b,
      input logic           b_sgn
   );
      logic signed [3:0]  ad [3];
      logic signed [3:0]  bd [3];
      logic signed [19:0] acc;
      ad[0] = {1'b0, a[2:0]};
      ad[1] = {1'b0, a[5:3]};
      ad[2] = {a_sgn & a[8], a[8:6]};
      bd[0] = {1'b0, b[2:0]};
      bd[1] = {1'b0, b[5:3]};
      bd[2] = {b_sgn & b[8], b[8:6]};
      acc   = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            acc = acc + ((20'(ad[i]) * 20'(bd[j])) <<< (3 * (i + j)));
         end
      end
      return acc[C_W-1:0];
   endfunction

   // -------------------------------------------------------------------------
   // One 4x4 lane: a 3-bit unsigned low digit plus a 1-bit top digit that is
   // negative-weighted when the lane is signed. Each lane owns its own small
   // grid, so no partial product crosses between lanes and no carry or sign
   // can leak from one lane into the other.
   // -------------------------------------------------------------------------
   function automatic logic [7:0] lane_mult(
      input logic [3:0] a,
      input logic       a_sgn,
      input logic [3:0] b,
      input logic       b_sgn
   );
      logic signed [3:0] a_lo;
      logic signed [3:0] b_lo;
      logic signed [1:0] a_hi;
      logic signed [1:0] b_hi;
      logic signed [9:0] acc;
      a_lo = {1'b0, a[2:0]};
      b_lo = {1'b0, b[2:0]};
      a_hi = {a_sgn & a[3], a[3]};
      b_hi = {b_sgn & b[3], b[3]};
      acc  =  (10'(a_lo) * 10'(b_lo))
           + ((10'(a_hi) * 10'(b_lo)) <<< 3)
           + ((10'(a_lo) * 10'(b_hi)) <<< 3)
           + ((10'(a_hi) * 10'(b_hi)) <<< 6);
      return acc[7:0];
   endfunction

   // -------------------------------------------------------------------------
   // Operand source: optional input register stage
   // -------------------------------------------------------------------------
   logic [A_W-1:0] op_a;
   logic [B_W-1:0] op_b;
   logic           op_a_sign;
   logic           op_b_sign;
   logic           op_half_0;
   logic           op_half_1;

`ifdef MULT_IN_REG_EN
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values present before the edge, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a      <= '0;
         op_b      <= '0;
         op_a_sign <= 1'b0;
         op_b_sign <= 1'b0;
         op_half_0 <= 1'b0;
         op_half_1 <= 1'b0;
      end else begin
         op_a      <= A;
         op_b      <= B;
         op_a_sign <= A_sign;
         op_b_sign <= B_sign;
         op_half_0 <= HALF_0;
         op_half_1 <= HALF_1;
      end
   end
`else
   assign op_a      = A;
   assign op_b      = B;
   assign op_a_sign = A_sign;
   assign op_b_sign = B_sign;
   assign op_half_0 = HALF_0;
   assign op_half_1 = HALF_1;
`endif

   // -------------------------------------------------------------------------
   // Mode select. A[4], B[4] are unused in dual mode and C[9:8] is forced low.
   // -------------------------------------------------------------------------
   logic [C_W-1:0] c_next;

   // NOTE: c_next gets a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      c_next = '0;
      if (op_half_1) begin
         c_next = {lane_mult(op_a[8:5], op_a_sign, op_b[8:5], op_b_sign),
                   2'b00,
                   lane_mult(op_a[3:0], op_a_sign, op_b[3:0], op_b_sign)};
      end else if (op_half_0) begin
         c_next = grid_mult(op_a, op_a_sign, op_b, op_b_sign);
      end
   end

   // -------------------------------------------------------------------------
   // Output register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         C <= '0;
      end else begin
         C <= c_next;
      end
   end

endmodule

// File: tb/tb_multiplier_s_c3x3_f1_9x9.sv
// ----------------------------------------------------------------------------
// tb_multiplier_s_c3x3_f1_9x9
//
// Scoreboard bench: the stimulus process drives one operation per cycle and
// pushes the expected C (spec constants for directed vectors, an integer
// arithmetic reference model for random ones) tagged with its issue cycle.
// A separate monitor pops and compares when that entry's latency has elapsed.
// ----------------------------------------------------------------------------
module tb_multiplier_s_c3x3_f1_9x9;

`ifdef MULT_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int N_RAND = 1500;

   logic        clk;
   logic        reset;
   logic [8:0]  A;
   logic [8:0]  B;
   logic        A_sign;
   logic        B_sign;
   logic        HALF_0;
   logic        HALF_1;
   logic [17:0] C;

   multiplier_s_c3x3_f1_9x9 dut (
      .clk    (clk),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .A_sign (A_sign),
      .B_sign (B_sign),
      .HALF_0 (HALF_0),
      .HALF_1 (HALF_1),
      .C      (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] exp;
      int          cyc;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cycle    = 0;
   int   checks   = 0;
   int   errors   = 0;
   bit   in_reset = 1'b1;

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: C=%05h expected %05h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: plain integer arithmetic on the field values.
   function automatic int fld(input logic [8:0] v, input int hi, input int lo, input logic sgn);
      int w;
      int u;
      w = hi - lo + 1;
      u = int'((v >> lo) & ((9'd1 << w) - 9'd1));
      if (sgn && u >= (1 << (w - 1))) u = u - (1 << w);
      return u;
   endfunction

   function automatic logic [17:0] ref_model(input logic [8:0] a, input logic [8:0] b,
                                             input logic as, input logic bs,
                                             input logic h0, input logic h1);
      int p_hi, p_lo, p;
      if (h1) begin
         p_hi = fld(a, 8, 5, as) * fld(b, 8, 5, bs);
         p_lo = fld(a, 3, 0, as) * fld(b, 3, 0, bs);
         return {8'(p_hi), 2'b00, 8'(p_lo)};
      end else if (h0) begin
         p = fld(a, 8, 0, as) * fld(b, 8, 0, bs);
         return 18'(p);
      end
      return 18'd0;
   endfunction

   // Drive one operation (caller is at a negedge) and enqueue its expectation.
   task automatic issue(input logic [8:0] a, input logic [8:0] b, input logic as,
                        input logic bs, input logic h0, input logic h1,
                        input logic [17:0] exp, input string tag);
      exp_t e;
      A = a; B = b; A_sign = as; B_sign = bs; HALF_0 = h0; HALF_1 = h1;
      e.exp = exp;
      e.cyc = cycle;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cycle++;
         #1;
         if (!in_reset && sb.size() > 0 && sb[0].cyc + LAT == cycle) begin
            e = sb.pop_front();
            check(e.tag, C, e.exp);
         end
      end
   end

   // Stimulus
   initial begin
      logic [8:0] ra, rb;
      logic       rh0, rh1;
      reset = 1'b1;
      A = '0; B = '0; A_sign = 1'b0; B_sign = 1'b0; HALF_0 = 1'b0; HALF_1 = 1'b0;

      @(posedge clk); #1;
      check("reset_init", C, 18'd0);
      @(negedge clk);
      reset    = 1'b0;
      in_reset = 1'b0;

      // Directed vectors
      issue(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 18'h3FC01, "unsigned_9x9");
      @(negedge clk);
      issue(9'h100, 9'h100, 1'b1, 1'b1, 1'b1, 1'b0, 18'h10000, "signed_9x9_min");
      @(negedge clk);
      issue(9'h1FF, 9'h100, 1'b0, 1'b1, 1'b1, 1'b0, 18'h20100, "mixed_9x9_min");
      @(negedge clk);
      issue(9'h1FF, 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b0, 18'h00001, "signed_neg1_sq");
      @(negedge clk);
      issue(9'h1EF, 9'h1EF, 1'b0, 1'b0, 1'b0, 1'b1, {8'hE1, 2'b00, 8'hE1}, "unsigned_4x4");
      @(negedge clk);
      issue(9'h107, 9'h119, 1'b1, 1'b1, 1'b1, 1'b1, {8'h40, 2'b00, 8'hCF}, "signed_4x4_bit4");
      @(negedge clk);
      issue(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00000, "idle");
      @(negedge clk);
      issue(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 18'h3FC01, "pre_reset_op");
      repeat (LAT + 1) @(negedge clk);

      // Asynchronous reset between edges: C clears at once and stays clear.
      #2;
      reset    = 1'b1;
      in_reset = 1'b1;
      sb.delete();
      #1;
      check("reset_async", C, 18'd0);
      @(posedge clk); #1;
      check("reset_hold", C, 18'd0);
      @(negedge clk);
      reset    = 1'b0;
      in_reset = 1'b0;
      issue(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 18'h3FC01, "post_reset_op");

      // Random regression over every mode / sign combination
      for (int mode = 0; mode < 3; mode++) begin
         for (int sg = 0; sg < 4; sg++) begin
            for (int n = 0; n < N_RAND; n++) begin
               @(negedge clk);
               ra  = 9'($urandom);
               rb  = 9'($urandom);
               rh1 = (mode == 1);
               rh0 = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
               issue(ra, rb, sg[1], sg[0], rh0, rh1,
                     ref_model(ra, rb, sg[1], sg[0], rh0, rh1), "random");
            end
         end
      end

      // Drain, bounded
      for (int k = 0; k < LAT + 4 && sb.size() > 0; k++) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
